// File: rtl/mmio_hub_if.sv
// mmio_hub_if: CPU word-bus connection for mmio_hub.
//   addr  [29:0]  word address          (CPU -> hub)
//   wdata [31:0]  write data            (CPU -> hub)
//   re            one-cycle read strobe (CPU -> hub)
//   we    [3:0]   byte write enables    (CPU -> hub)
//   rdata [31:0]  registered read data  (hub -> CPU)
//   hit_q         registered window hit (hub -> CPU)
interface mmio_hub_if;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        hit_q;

  modport master (output addr, wdata, re, we, input rdata, hit_q);
  modport slave  (input addr, wdata, re, we, output rdata, hit_q);
endinterface

// File: rtl/mmio_hub.sv
// mmio_hub: 8-word MMIO window with GPO (set/clear), 2-flop synchronised GPI,
// prescaled tick timer and sticky STATUS. Read data is registered (RAM-like).
// Optional feature macro: MMIO_HUB_TIMER_CMP_EN (CMP register + compare irq).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    mmio_hub_if.slave (addr, wdata, re, we, rdata, hit_q)
//   gpo    general-purpose outputs [NUM_OUT-1:0]
//   gpi    asynchronous inputs [NUM_IN-1:0]
//   irq    compare interrupt (0 unless MMIO_HUB_TIMER_CMP_EN)
module mmio_hub #(
  parameter logic [29:0] BASE_WORD = 30'h4010,
  parameter int unsigned NUM_OUT   = 8,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned TICK_HZ   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  mmio_hub_if.slave          bus,
  output logic [NUM_OUT-1:0] gpo,
  input  logic [NUM_IN-1:0]  gpi,
  output logic               irq
);
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic [NUM_OUT-1:0] gpo_q, gpo_d;
  logic [NUM_IN-1:0]  gpi_s1_q, gpi_s2_q;
  logic [31:0]        count_q, count_d, count_inc;
  logic [PW-1:0]      presc_q, presc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               hit_q_q;
  logic               cmp_hit_q, cmp_hit_d;
  logic               err_q, err_d;
  logic               irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
`ifdef MMIO_HUB_TIMER_CMP_EN
  logic [31:0]        cmp_q, cmp_d;
`endif

  logic        hit, wr, partial, tick, cmp_set, err_set;
  logic [2:0]  off;
  logic [31:0] rd_val;

  always_comb begin
    hit     = (bus.addr[29:3] == BASE_WORD[29:3]);
    off     = bus.addr[2:0];
    wr      = hit && (bus.we == 4'hF);
    partial = hit && (bus.we != 4'h0) && (bus.we != 4'hF);
    err_set = partial || (hit && (off == 3'd7) && (bus.re || (bus.we != 4'h0)));
  end

  // Read mux sees only current flop values, so a same-cycle write reads back the old value.
  always_comb begin
    rd_val = '0;
    case (off)
      3'd0, 3'd1, 3'd2: rd_val = 32'(gpo_q);
      3'd3:             rd_val = 32'(gpi_s2_q);
      3'd4:             rd_val = count_q;
`ifdef MMIO_HUB_TIMER_CMP_EN
      3'd5:             rd_val = cmp_q;
`endif
      3'd6:             rd_val = {29'b0, irq_en_q, err_q, cmp_hit_q};
      default:          rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d = (bus.re && hit) ? rd_val : rdata_q;

    gpo_d = gpo_q;
    if (wr) begin
      case (off)
        3'd0:    gpo_d = bus.wdata[NUM_OUT-1:0];
        3'd1:    gpo_d = gpo_q | bus.wdata[NUM_OUT-1:0];
        3'd2:    gpo_d = gpo_q & ~bus.wdata[NUM_OUT-1:0];
        default: gpo_d = gpo_q;
      endcase
    end

    // Timer: a COUNT write overrides a coincident increment and restarts the prescaler.
    tick      = (presc_q == PW'(DIV - 1));
    count_inc = count_q + 32'd1;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    count_d   = tick ? count_inc : count_q;
    if (wr && off == 3'd4) begin
      count_d = bus.wdata;
      presc_d = '0;
    end

`ifdef MMIO_HUB_TIMER_CMP_EN
    cmp_d   = (wr && off == 3'd5) ? bus.wdata : cmp_q;
    cmp_set = tick && !(wr && off == 3'd4) && (count_inc == cmp_q);
    irq_d   = cmp_hit_q && irq_en_q;
`else
    cmp_set = 1'b0;
    irq_d   = 1'b0;
`endif

    // Sticky flags: W1C applied first, so a coincident set wins.
    cmp_hit_d = cmp_hit_q;
    err_d     = err_q;
    irq_en_d  = irq_en_q;
    if (wr && off == 3'd6) begin
      cmp_hit_d = cmp_hit_q & ~bus.wdata[0];
      err_d     = err_q & ~bus.wdata[1];
      irq_en_d  = bus.wdata[2];
    end
    if (cmp_set) cmp_hit_d = 1'b1;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpo_q     <= '0;
      gpi_s1_q  <= '0;
      gpi_s2_q  <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      rdata_q   <= '0;
      hit_q_q   <= 1'b0;
      cmp_hit_q <= 1'b0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`ifdef MMIO_HUB_TIMER_CMP_EN
      cmp_q     <= '1;
`endif
    end else begin
      gpo_q     <= gpo_d;
      gpi_s1_q  <= gpi;
      gpi_s2_q  <= gpi_s1_q;
      count_q   <= count_d;
      presc_q   <= presc_d;
      rdata_q   <= rdata_d;
      hit_q_q   <= hit;
      cmp_hit_q <= cmp_hit_d;
      err_q     <= err_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
`ifdef MMIO_HUB_TIMER_CMP_EN
      cmp_q     <= cmp_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.hit_q = hit_q_q;
  assign gpo       = gpo_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_mmio_hub.sv
module tb_mmio_hub;
  localparam logic [29:0] BASE = 30'h4010;
  localparam int unsigned DIV  = 4;
`ifdef MMIO_HUB_TIMER_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpo;
  logic [3:0] gpi;
  logic       irq;

  mmio_hub_if bus();

  mmio_hub #(
    .BASE_WORD(BASE), .NUM_OUT(8), .NUM_IN(4), .CLK_HZ(4), .TICK_HZ(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .gpo(gpo), .gpi(gpi), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: count is derived from elapsed edges since the last load.
  int unsigned cyc  = 0;
  int unsigned wcyc = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_cmp = '1;
  logic [7:0]  m_gpo = '0;
  logic        m_cmp_hit = 0, m_err = 0, m_irq_en = 0, m_irq = 0, m_hitq = 0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  gh1 = '0, gh2 = '0;

  function automatic logic [31:0] count_at(int unsigned c);
    return m_base + 32'((c - wcyc) / DIV);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(string tag, logic rst, logic [29:0] a, logic [31:0] wd,
                      logic r, logic [3:0] w);
    logic hit, wr, cset, eset, irq_n;
    logic [2:0]  off;
    logic [31:0] rv, cnow, cnext;
    reset = rst; bus.addr = a; bus.wdata = wd; bus.re = r; bus.we = w;
    hit  = (a[29:3] == BASE[29:3]);
    off  = a[2:0];
    wr   = hit && (w == 4'hF);
    cnow = count_at(cyc);
    case (off)
      3'd0, 3'd1, 3'd2: rv = {24'b0, m_gpo};
      3'd3: rv = {28'b0, gh2};
      3'd4: rv = cnow;
      3'd5: rv = CMP_EN ? m_cmp : 32'b0;
      3'd6: rv = {29'b0, m_irq_en, m_err, m_cmp_hit};
      default: rv = '0;
    endcase
    if (rst) begin
      m_gpo = '0; m_rdata = '0; m_hitq = 0; m_base = '0; wcyc = cyc + 1;
      m_cmp = '1; m_cmp_hit = 0; m_err = 0; m_irq_en = 0; m_irq = 0;
      gh1 = '0; gh2 = '0;
    end else begin
      irq_n  = CMP_EN && m_cmp_hit && m_irq_en;
      cnext  = count_at(cyc + 1);
      cset   = CMP_EN && !(wr && off == 3'd4) && (cnext != cnow) && (cnext == m_cmp);
      eset   = (hit && w != 4'h0 && w != 4'hF) || (hit && off == 3'd7 && (r || w != 4'h0));
      m_hitq = hit;
      if (r && hit) m_rdata = rv;
      m_irq = irq_n;
      if (wr) begin
        case (off)
          3'd0: m_gpo = wd[7:0];
          3'd1: m_gpo = m_gpo | wd[7:0];
          3'd2: m_gpo = m_gpo & ~wd[7:0];
          3'd4: begin m_base = wd; wcyc = cyc + 1; end
          3'd5: if (CMP_EN) m_cmp = wd;
          3'd6: begin
            m_cmp_hit = m_cmp_hit & ~wd[0];
            m_err     = m_err & ~wd[1];
            m_irq_en  = wd[2];
          end
          default: ;
        endcase
      end
      if (cset) m_cmp_hit = 1'b1;
      if (eset) m_err = 1'b1;
      gh2 = gh1; gh1 = gpi;
    end
    @(posedge clk); #1; cyc++;
    check({tag, ".rdata"}, bus.rdata, m_rdata);
    check({tag, ".hit_q"}, {31'b0, bus.hit_q}, {31'b0, m_hitq});
    check({tag, ".gpo"}, {24'b0, gpo}, {24'b0, m_gpo});
    check({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(string tag, int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(tag, 0, 30'h0, 32'h0, 0, 4'h0);
  endtask

  initial begin
    logic [29:0] ra;
    logic [31:0] rw;
    logic [3:0]  rwe;
    gpi = '0;
    // 1: reset state
    step("rst", 1, BASE, 0, 0, 0);
    step("rst", 1, BASE, 0, 0, 0);
    step("t1.r0", 0, BASE + 0, 0, 1, 0);
    check("t1.r0.const", bus.rdata, 32'h0);
    check("t1.hitq.const", {31'b0, bus.hit_q}, 32'h1);
    step("t1.r4", 0, BASE + 4, 0, 1, 0);
    step("t1.r6", 0, BASE + 6, 0, 1, 0);
    check("t1.r6.const", bus.rdata, 32'h0);
    // 2: GPO / SET / CLR
    step("t2.w0", 0, BASE + 0, 32'hA5, 0, 4'hF);
    check("t2.gpo0", {24'b0, gpo}, 32'hA5);
    step("t2.w1", 0, BASE + 1, 32'h0A, 0, 4'hF);
    check("t2.gpo1", {24'b0, gpo}, 32'hAF);
    step("t2.w2", 0, BASE + 2, 32'h81, 0, 4'hF);
    check("t2.gpo2", {24'b0, gpo}, 32'h2E);
    step("t2.r1", 0, BASE + 1, 0, 1, 0);
    check("t2.r1.const", bus.rdata, 32'h2E);
    // 3: counter wrap
    step("t3.w4", 0, BASE + 4, 32'hFFFF_FFFE, 0, 4'hF);
    idle("t3.wait", 8);
    step("t3.r4", 0, BASE + 4, 0, 1, 0);
    check("t3.wrap.const", bus.rdata, 32'h0);
    // 4: compare / irq / W1C vs coincident set
    step("t4.cmp", 0, BASE + 5, 32'd3, 0, 4'hF);
    step("t4.en", 0, BASE + 6, 32'h4, 0, 4'hF);
    step("t4.cnt", 0, BASE + 4, 32'd0, 0, 4'hF);
    idle("t4.wait", 14);
    step("t4.w1c", 0, BASE + 6, 32'h1, 0, 4'hF);
    idle("t4.drop", 2);
    step("t4.cnt2", 0, BASE + 4, 32'd2, 0, 4'hF);
    idle("t4.pre", 3);
    step("t4.coin", 0, BASE + 6, 32'h5, 0, 4'hF);
    step("t4.rs", 0, BASE + 6, 0, 1, 0);
    check("t4.flag.const", bus.rdata & 32'h1, CMP_EN ? 32'h1 : 32'h0);
    idle("t4.irq", 2);
    // 5: GPI synchroniser latency, out-of-window read
    gpi = 4'hF;
    step("t5.g0", 0, BASE + 3, 0, 1, 0);
    check("t5.g0.const", bus.rdata, 32'h0);
    step("t5.g1", 0, BASE + 3, 0, 1, 0);
    check("t5.g1.const", bus.rdata, 32'h0);
    step("t5.g2", 0, BASE + 3, 0, 1, 0);
    check("t5.g2.const", bus.rdata, 32'hF);
    step("t5.out", 0, BASE + 8, 0, 1, 0);
    check("t5.out.const", {31'b0, bus.hit_q}, 32'h0);
    // 6: partial write, off7 access, reset mid-read
    step("t6.clr", 0, BASE + 6, 32'h2, 0, 4'hF);
    step("t6.part", 0, BASE + 0, 32'h00, 0, 4'b0011);
    step("t6.rs", 0, BASE + 6, 0, 1, 0);
    check("t6.err.const", bus.rdata & 32'h2, 32'h2);
    step("t6.clr2", 0, BASE + 6, 32'h2, 0, 4'hF);
    step("t6.off7", 0, BASE + 7, 0, 1, 0);
    step("t6.rs2", 0, BASE + 6, 0, 1, 0);
    step("t6.rd", 0, BASE + 4, 0, 1, 0);
    step("t6.rst", 1, BASE + 4, 0, 1, 0);
    check("t6.rst.const", bus.rdata, 32'h0);
    // Randomised traffic
    for (int unsigned i = 0; i < 400; i++) begin
      ra  = ($urandom_range(0, 9) < 9) ? (BASE + 30'($urandom_range(0, 7))) : 30'($urandom);
      rw  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1: rwe = 4'h0;
        2: rwe = 4'hF;
        default: rwe = 4'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) gpi = 4'($urandom);
      step("rnd", ($urandom_range(0, 99) == 0), ra, rw, 1'($urandom), rwe);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
